// File: rtl/framebuffer_line_serializer_pkg.sv
// Shared defaults and small helpers for the framebuffer line serializer.
// Derived widths stay local to each module so that every instance can be parameterised alone.
package framebuffer_line_serializer_pkg;

   localparam int unsigned DEF_STREAM_WIDTH    = 64;
   localparam int unsigned DEF_ADDR_WIDTH      = 32;
   localparam int unsigned DEF_ID_WIDTH        = 8;
   localparam int unsigned DEF_PIXEL_WIDTH     = 16;
   localparam int unsigned DEF_BEAT_FIFO_DEPTH = 4;

   localparam logic [1:0] RRESP_OKAY = 2'b00;

   function automatic int unsigned pix_per_beat(input int unsigned stream_w,
                                                input int unsigned pixel_w);
      return stream_w / pixel_w;
   endfunction

endpackage

// File: rtl/framebuffer_line_serializer_if.sv
// Fetch, memory read and pixel output streams of the line serializer.
// The master modport is the serializer itself; slave is the surrounding system.
interface framebuffer_line_serializer_if
   import framebuffer_line_serializer_pkg::*;
#(
   parameter int unsigned STREAM_WIDTH = DEF_STREAM_WIDTH,
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned ID_WIDTH     = DEF_ID_WIDTH,
   parameter int unsigned PIXEL_WIDTH  = DEF_PIXEL_WIDTH
);

   logic                    s_fetch_axis_tvalid;
   logic                    s_fetch_axis_tready;
   logic                    s_fetch_axis_tlast;
   logic [ADDR_WIDTH-1:0]   s_fetch_axis_tdest;

   logic [ID_WIDTH-1:0]     m_mem_axi_rid;
   logic [STREAM_WIDTH-1:0] m_mem_axi_rdata;
   logic [1:0]              m_mem_axi_rresp;
   logic                    m_mem_axi_rlast;
   logic                    m_mem_axi_rvalid;
   logic                    m_mem_axi_rready;

   logic                    m_frag_axis_tvalid;
   logic                    m_frag_axis_tready;
   logic                    m_frag_axis_tlast;
   logic [PIXEL_WIDTH-1:0]  m_frag_axis_tdata;
   logic [ADDR_WIDTH-1:0]   m_frag_axis_tdest;

   logic                    err_rresp;

   modport master (
      input  s_fetch_axis_tvalid, s_fetch_axis_tlast, s_fetch_axis_tdest,
      output s_fetch_axis_tready,
      input  m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp, m_mem_axi_rlast,
      input  m_mem_axi_rvalid,
      output m_mem_axi_rready,
      output m_frag_axis_tvalid, m_frag_axis_tlast, m_frag_axis_tdata, m_frag_axis_tdest,
      input  m_frag_axis_tready,
      output err_rresp
   );

   modport slave (
      output s_fetch_axis_tvalid, s_fetch_axis_tlast, s_fetch_axis_tdest,
      input  s_fetch_axis_tready,
      output m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp, m_mem_axi_rlast,
      output m_mem_axi_rvalid,
      input  m_mem_axi_rready,
      input  m_frag_axis_tvalid, m_frag_axis_tlast, m_frag_axis_tdata, m_frag_axis_tdest,
      output m_frag_axis_tready,
      input  err_rresp
   );

endinterface

// File: rtl/framebuffer_line_serializer_beat_fifo.sv
// Small circular FIFO holding memory read beats until a line miss consumes them.
// Storage is not reset; only pointers and the occupancy count are.
module beat_fifo
   import framebuffer_line_serializer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_STREAM_WIDTH,
   parameter int unsigned DEPTH      = DEF_BEAT_FIFO_DEPTH
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          push_i,
   input  logic [DATA_WIDTH-1:0]         data_i,
   input  logic                          pop_i,
   output logic [DATA_WIDTH-1:0]         data_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [$clog2(DEPTH):0]        count_o
);

   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
   localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  do_push, do_pop;

   assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Guard against misuse even though the top never pushes when full or pops when empty.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_WIDTH'(1);
         2'b01:   count_d = count_q - CNT_WIDTH'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/framebuffer_line_serializer.sv
// Turns a stream of pixel addresses into a stream of pixels, using one cached memory line
// and a FIFO of prefetched read beats; every line miss consumes exactly one beat.
module framebuffer_line_serializer
   import framebuffer_line_serializer_pkg::*;
#(
   parameter int unsigned STREAM_WIDTH    = DEF_STREAM_WIDTH,
   parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int unsigned ID_WIDTH        = DEF_ID_WIDTH,
   parameter int unsigned PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
   parameter int unsigned BEAT_FIFO_DEPTH = DEF_BEAT_FIFO_DEPTH
) (
   input  logic                          aclk,
   input  logic                          areset,
   framebuffer_line_serializer_if.master bus
);

   localparam int unsigned PIX_PER_BEAT = pix_per_beat(STREAM_WIDTH, PIXEL_WIDTH);
   localparam int unsigned P            = $clog2(PIX_PER_BEAT);
   localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - P;
   localparam int unsigned CNT_WIDTH    = $clog2(BEAT_FIFO_DEPTH) + 1;

   logic [TAG_WIDTH-1:0]    fetch_tag;
   logic [31:0]             slot_shift;
   logic [STREAM_WIDTH-1:0] fifo_head;
   logic [STREAM_WIDTH-1:0] src_line;
   logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [CNT_WIDTH-1:0]    fifo_count;
   logic                    hit, out_free, fetch_ready, accept;

   logic [STREAM_WIDTH-1:0] line_q, line_d;
   logic [TAG_WIDTH-1:0]    line_tag_q, line_tag_d;
   logic                    line_valid_q, line_valid_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic [PIXEL_WIDTH-1:0]  out_data_q, out_data_d;
   logic [ADDR_WIDTH-1:0]   out_dest_q, out_dest_d;
   logic                    err_q, err_d;

   // A single pixel per beat has no slot bits: the whole address is the tag.
   if (P == 0) begin : g_no_slot
      assign fetch_tag  = bus.s_fetch_axis_tdest;
      assign slot_shift = '0;
   end else begin : g_slot
      assign fetch_tag  = bus.s_fetch_axis_tdest[ADDR_WIDTH-1:P];
      assign slot_shift = 32'(bus.s_fetch_axis_tdest[P-1:0]) * 32'(PIXEL_WIDTH);
   end

   assign fifo_push = bus.m_mem_axi_rvalid && bus.m_mem_axi_rready;

   beat_fifo #(
      .DATA_WIDTH (STREAM_WIDTH),
      .DEPTH      (BEAT_FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (aclk),
      .rst_i   (areset),
      .push_i  (fifo_push),
      .data_i  (bus.m_mem_axi_rdata),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Tag match needs the separate valid bit so an all-ones tag is not mistaken for "empty".
   assign hit         = line_valid_q && (line_tag_q == fetch_tag);
   assign out_free    = !out_valid_q || bus.m_frag_axis_tready;
   assign fetch_ready = out_free && (hit || (fifo_count != '0));
   assign accept      = bus.s_fetch_axis_tvalid && fetch_ready;
   assign fifo_pop    = accept && !hit;
   assign src_line    = hit ? line_q : fifo_head;

   always_comb begin
      line_d       = line_q;
      line_tag_d   = line_tag_q;
      line_valid_d = line_valid_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_data_d   = out_data_q;
      out_dest_d   = out_dest_q;
      err_d        = err_q;

      if (fifo_push && (bus.m_mem_axi_rresp != RRESP_OKAY)) err_d = 1'b1;

      if (accept) begin
         if (!hit) begin
            line_d     = fifo_head;
            line_tag_d = fetch_tag;
         end
         // End of a line invalidates it so the next fetch always takes a fresh beat.
         line_valid_d = !bus.s_fetch_axis_tlast;
         out_valid_d  = 1'b1;
         out_last_d   = bus.s_fetch_axis_tlast;
         out_data_d   = PIXEL_WIDTH'(src_line >> slot_shift);
         out_dest_d   = bus.s_fetch_axis_tdest;
      end else if (bus.m_frag_axis_tready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         line_valid_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         line_valid_q <= line_valid_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         err_q        <= err_d;
      end
   end

   always_ff @(posedge aclk) begin
      line_q     <= line_d;
      line_tag_q <= line_tag_d;
      out_data_q <= out_data_d;
      out_dest_q <= out_dest_d;
   end

   assign bus.s_fetch_axis_tready = fetch_ready;
   assign bus.m_mem_axi_rready    = !fifo_full;
   assign bus.m_frag_axis_tvalid  = out_valid_q;
   assign bus.m_frag_axis_tlast   = out_last_q;
   assign bus.m_frag_axis_tdata   = out_data_q;
   assign bus.m_frag_axis_tdest   = out_dest_q;
   assign bus.err_rresp           = err_q;

   logic unused_sigs;
   assign unused_sigs = ^{bus.m_mem_axi_rid, bus.m_mem_axi_rlast, fifo_empty};

endmodule

// File: tb/tb_framebuffer_line_serializer.sv
// Self-checking bench: queue-driven fetch and memory streams, scoreboard on the pixel output,
// a vector table for the main flow and hand-written sequences for stalls and reset.
module tb_framebuffer_line_serializer;
   import framebuffer_line_serializer_pkg::*;

   localparam int unsigned SW = 64, AW = 32, IW = 8, PW = 16, DEPTH = 4;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   framebuffer_line_serializer_if #(
      .STREAM_WIDTH (SW), .ADDR_WIDTH (AW), .ID_WIDTH (IW), .PIXEL_WIDTH (PW)
   ) bus ();

   framebuffer_line_serializer #(
      .STREAM_WIDTH (SW), .ADDR_WIDTH (AW), .ID_WIDTH (IW), .PIXEL_WIDTH (PW),
      .BEAT_FIFO_DEPTH (DEPTH)
   ) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic          last;
      logic [PW-1:0] data;
   } fetch_t;

   fetch_t        vecs [12];
   fetch_t        fq [$];
   fetch_t        sb [$];
   logic [SW-1:0] bq [$];
   logic [1:0]    rq [$];
   int            out_cyc [$];

   int n_checks = 0, n_err = 0, cyc = 0;
   int fetch_taken = 0, beats_taken = 0;
   bit mem_en = 1'b1, fetch_en = 1'b1, out_rdy = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive();
      bus.s_fetch_axis_tvalid = fetch_en && (fq.size() > 0);
      if (fq.size() > 0) begin
         bus.s_fetch_axis_tdest = fq[0].addr;
         bus.s_fetch_axis_tlast = fq[0].last;
      end
      bus.m_mem_axi_rvalid = mem_en && (bq.size() > 0);
      if (bq.size() > 0) begin
         bus.m_mem_axi_rdata = bq[0];
         bus.m_mem_axi_rresp = rq[0];
      end
      bus.m_frag_axis_tready = out_rdy;
   endtask

   task automatic push_beat(input logic [SW-1:0] b, input logic [1:0] r);
      bq.push_back(b);
      rq.push_back(r);
   endtask

   task automatic push_fetch(input logic [AW-1:0] a, input logic l, input logic [PW-1:0] d);
      fetch_t f;
      f.addr = a;
      f.last = l;
      f.data = d;
      fq.push_back(f);
   endtask

   // One clock: drive, sample handshakes on the falling edge, retire them after the rising edge.
   task automatic cycle();
      bit     f_fire, m_fire, o_fire;
      fetch_t e;
      drive();
      @(negedge aclk);
      f_fire = bus.s_fetch_axis_tvalid && bus.s_fetch_axis_tready;
      m_fire = bus.m_mem_axi_rvalid && bus.m_mem_axi_rready;
      o_fire = bus.m_frag_axis_tvalid && bus.m_frag_axis_tready;
      if (o_fire) begin
         out_cyc.push_back(cyc);
         chk("sb_has_entry", 64'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_data", bus.m_frag_axis_tdata, e.data);
            chk("out_dest", bus.m_frag_axis_tdest, e.addr);
            chk("out_last", bus.m_frag_axis_tlast, e.last);
         end
      end
      @(posedge aclk);
      #1;
      cyc++;
      if (f_fire) begin
         sb.push_back(fq.pop_front());
         fetch_taken++;
      end
      if (m_fire) begin
         void'(bq.pop_front());
         void'(rq.pop_front());
         beats_taken++;
      end
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((fq.size() != 0 || sb.size() != 0) && n < max_cyc) begin
         cycle();
         n++;
      end
      chk("drain_done", 64'(fq.size() + sb.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int        n, ft0, bt0;
      logic [SW-1:0] b;

      for (int i = 0; i < 8; i++) begin
         vecs[i].addr = AW'(i);
         vecs[i].last = (i == 7);
         vecs[i].data = PW'(i + 1);
      end
      vecs[8]  = '{addr: 32'h20, last: 1'b0, data: 16'hAAAA};
      vecs[9]  = '{addr: 32'h23, last: 1'b0, data: 16'hDDDD};
      vecs[10] = '{addr: 32'h21, last: 1'b1, data: 16'hBBBB};
      vecs[11] = '{addr: 32'h40, last: 1'b1, data: 16'hCDEF};

      bus.m_mem_axi_rid  = '0;
      bus.m_mem_axi_rlast = 1'b0;
      bus.m_mem_axi_rdata = '0;
      bus.m_mem_axi_rresp = '0;
      bus.s_fetch_axis_tdest = '0;
      bus.s_fetch_axis_tlast = 1'b0;
      drive();
      repeat (3) @(posedge aclk);
      #1;
      areset = 1'b0;
      #1;
      chk("reset_tvalid", bus.m_frag_axis_tvalid, 0);
      chk("reset_tlast", bus.m_frag_axis_tlast, 0);
      chk("reset_rready", bus.m_mem_axi_rready, 1);
      chk("reset_err", bus.err_rresp, 0);
      chk("reset_fetch_tready", bus.s_fetch_axis_tready, 0);

      // Table: sequential slots, then out-of-order hits and an isolated miss.
      push_beat(64'h0004_0003_0002_0001, 2'b00);
      push_beat(64'h0008_0007_0006_0005, 2'b00);
      push_beat(64'hDDDD_CCCC_BBBB_AAAA, 2'b00);
      push_beat(64'h1234_5678_90AB_CDEF, 2'b00);
      for (int i = 0; i < 12; i++) push_fetch(vecs[i].addr, vecs[i].last, vecs[i].data);
      out_cyc.delete();
      drain(200);
      chk("outputs_seen", 64'(out_cyc.size()), 12);
      if (out_cyc.size() >= 8) chk("eight_consecutive", 64'(out_cyc[7] - out_cyc[0]), 7);
      chk("fifo_empty_after", 64'(dut.u_fifo.count_o), 0);

      // Miss with empty FIFO stalls; the beat is not bypassed.
      mem_en = 1'b0;
      push_fetch(32'h5, 1'b1, 16'h0006);
      push_beat(64'h0008_0007_0006_0005, 2'b00);
      repeat (3) begin
         cycle();
         chk("stall_tready", bus.s_fetch_axis_tready, 0);
      end
      mem_en = 1'b1;
      drive();
      #1;
      chk("no_bypass_tready", bus.s_fetch_axis_tready, 0);
      cycle();
      chk("tready_after_push", bus.s_fetch_axis_tready, 1);
      cycle();
      chk("out_valid_after_accept", bus.m_frag_axis_tvalid, 1);
      chk("out_data_after_accept", bus.m_frag_axis_tdata, 16'h0006);
      drain(20);

      // Output back-pressure for five cycles mid-stream.
      push_beat(64'h000C_000B_000A_0009, 2'b00);
      push_beat(64'h0010_000F_000E_000D, 2'b00);
      for (int i = 0; i < 8; i++) push_fetch(32'h100 + AW'(i), i == 7, PW'(9 + i));
      repeat (4) cycle();
      out_rdy = 1'b0;
      cycle();
      ft0 = fetch_taken;
      chk("hold_valid", bus.m_frag_axis_tvalid, 1);
      repeat (5) begin
         cycle();
         chk("hold_sb_entry", 64'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            chk("hold_data", bus.m_frag_axis_tdata, sb[0].data);
            chk("hold_dest", bus.m_frag_axis_tdest, sb[0].addr);
            chk("hold_last", bus.m_frag_axis_tlast, sb[0].last);
         end
         chk("hold_no_fetch_ready", bus.s_fetch_axis_tready, 0);
         chk("hold_no_accept", 64'(fetch_taken - ft0), 0);
      end
      out_rdy = 1'b1;
      drain(100);

      // FIFO fills to its depth, then drains one beat per popping fetch.
      fetch_en = 1'b0;
      bt0 = beats_taken;
      for (int k = 1; k <= 6; k++) begin
         b = (64'(k) << 48) | 64'(16'h0A00 + k);
         push_beat(b, 2'b00);
         push_fetch(AW'((32'h200 + k) << 2), 1'b1, PW'(16'h0A00 + k));
      end
      repeat (8) cycle();
      chk("beats_before_pop", 64'(beats_taken - bt0), 4);
      chk("rready_full", bus.m_mem_axi_rready, 0);
      fetch_en = 1'b1;
      ft0 = fetch_taken;
      n = 0;
      while (fetch_taken == ft0 && n < 10) begin
         cycle();
         n++;
      end
      chk("rready_after_pop", bus.m_mem_axi_rready, 1);
      drain(100);
      chk("all_six_beats", 64'(beats_taken - bt0), 6);

      // All-ones address and error response.
      chk("err_clear_before", bus.err_rresp, 0);
      push_beat(64'h1111_2222_3333_4444, 2'b00);
      push_beat(64'h5555_6666_7777_8888, 2'b10);
      push_fetch(32'hFFFF_FFFF, 1'b1, 16'h1111);
      push_fetch(32'hFFFF_FFFC, 1'b1, 16'h8888);
      drain(50);
      chk("err_set", bus.err_rresp, 1);
      repeat (3) cycle();
      chk("err_sticky", bus.err_rresp, 1);

      // Asynchronous reset with beats buffered and a pending output.
      out_rdy = 1'b0;
      push_beat(64'h0101_0202_0303_0404, 2'b00);
      push_beat(64'h0505_0606_0707_0808, 2'b00);
      push_beat(64'h0909_0A0A_0B0B_0C0C, 2'b00);
      push_fetch(32'h0, 1'b0, 16'h0404);
      repeat (5) cycle();
      chk("pre_reset_valid", bus.m_frag_axis_tvalid, 1);
      chk("pre_reset_beats", 64'(bq.size()), 0);
      @(negedge aclk);
      #2;
      areset = 1'b1;
      #1;
      chk("rst_tvalid", bus.m_frag_axis_tvalid, 0);
      chk("rst_rready", bus.m_mem_axi_rready, 1);
      chk("rst_fetch_tready", bus.s_fetch_axis_tready, 0);
      chk("rst_err", bus.err_rresp, 0);
      sb.delete();
      fq.delete();
      bq.delete();
      rq.delete();
      out_rdy = 1'b1;
      drive();
      @(posedge aclk);
      #1;
      areset = 1'b0;
      push_beat(64'h9999_AAAA_BBBB_CCCC, 2'b00);
      push_fetch(32'h2, 1'b1, 16'hAAAA);
      drain(50);

      chk("sb_empty_end", 64'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
